branch_predict_ctrl: RTL and testbench
======================================

Name: branch_predict_ctrl

Overview:
- Branch prediction and redirect controller for the 5-stage RISC-V pipeline.
- Holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
- Predicts in Fetch, carries the prediction to Execute in its own pipeline registers, and resolves it against the Execute-stage branch outcome.
- On a miss it drives the redirect PC and the flush requests consumed by the hazard unit, and keeps branch/mispredict statistics counters.

Parameters:
- IDX_W, 6, BTB index width; ENTRIES = 2**IDX_W; index = PC[IDX_W+1:2].
- TAG_W, 32-IDX_W-2, tag width; tag = PC[31:IDX_W+2].
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- PCF  in  32  Fetch-stage PC.
- PredTakenF  out  1  Fetch predicts taken (combinational).
- PredTargetF  out  32  predicted target (combinational).
- StallD  in  1  hold the F->D prediction register.
- FlushD  in  1  clear the F->D prediction register.
- FlushE  in  1  clear the D->E prediction register.
- PCE  in  32  Execute-stage PC.
- PCTargetE  in  32  computed branch/jal target.
- PCPlus4E  in  32  fall-through PC.
- BranchE  in  1  conditional branch in Execute.
- JumpE  in  1  jal in Execute.
- JalrE  in  1  jalr in Execute; never predicted or trained.
- PCSrcE  in  1  actual taken outcome.
- MispredictE  out  1  prediction wrong (combinational).
- RedirectPCE  out  32  correct next PC when MispredictE = 1.
- BranchCount  out  CNT_W  resolved branch + jal count.
- MispredictCount  out  CNT_W  mispredict count.

Behaviour:
- Storage: per entry valid, tag[TAG_W], target[32], ctr[2].
- Reset (rst = 0, asynchronous):
  - all valid = 0, all ctr = 2'b01.
  - PredD, PredE, PredTargetD, PredTargetE = 0.
  - both statistics counters = 0.
  - outputs therefore read PredTakenF = 0, MispredictE = 0, counts = 0.
- Reset asserted mid-operation discards all state immediately; no update completes on that edge.
- Fetch lookup (combinational, 0 latency):
  - hit = valid[idx] & (tag[idx] == PCF tag).
  - PredTakenF = hit & ctr[1].
  - PredTargetF = target[idx] when PredTakenF = 1, else PCF + 4.
- Prediction pipeline, sampled on clk:
  - F->D: FlushD clears to 0; else StallD holds; else loads (PredTakenF, PredTargetF). Flush has priority over stall.
  - D->E: FlushE clears to 0; else loads from D.
- Resolution in Execute (combinational):
  - resolvable = (BranchE | JumpE) & ~JalrE.
  - Case A: resolvable & (PredE != PCSrcE) -> mispredict.
  - Case B: resolvable & PredE & PCSrcE & (PredTargetE != PCTargetE) -> mispredict.
  - Case C: ~resolvable & PredE (alias or stale hit on a non-branch) -> mispredict.
  - MispredictE = A | B | C.
  - RedirectPCE = PCTargetE if (resolvable & PCSrcE), else PCPlus4E.
  - The hazard unit ORs MispredictE into FlushD and FlushE.
- BTB update, on the clk edge, at index/tag of PCE:
  - resolvable & entry hit, taken: ctr saturating +1 (3 stays 3); target <= PCTargetE.
  - resolvable & entry hit, not taken: ctr saturating -1 (0 stays 0).
  - resolvable & miss & taken: allocate; valid = 1, tag, target = PCTargetE, ctr = 2'b10. Replaces any existing entry.
  - resolvable & miss & not taken: no write.
  - JumpE: ctr forced to 2'b11 on hit or allocate.
  - Case C: valid[idx] <= 0.
- Same-cycle read and write of one index: Fetch sees the pre-update value (no bypass).
- Statistics counters:
  - BranchCount +1 per resolvable cycle.
  - MispredictCount +1 per MispredictE cycle.
  - Both saturate at all-ones; no wrap.

Test Plan:
- Reset, then PCF = 0x100 -> PredTakenF = 0, PredTargetF = 0x104, both counts 0.
- Taken beq at PCE = 0x100, target 0x80, PredE = 0 -> MispredictE = 1, RedirectPCE = 0x80. Next cycle PCF = 0x100 gives PredTakenF = 1, PredTargetF = 0x80; ctr = 2.
- Same branch resolved not-taken twice with PredE = 1 then 0 -> first: MispredictE = 1, RedirectPCE = PCE + 4, ctr 2->1. Second: no mispredict, ctr 1->0. Then PredTakenF = 0.
- Predicted taken to 0x80, actual target 0x90 -> MispredictE = 1 (Case B), RedirectPCE = 0x90, entry target updated to 0x90.
- PredE = 1 with BranchE = JumpE = 0 -> MispredictE = 1, RedirectPCE = PCPlus4E, entry invalidated.
- StallD = 1 and FlushD = 1 in the same cycle -> PredD = 0. Pull rst low mid-stream -> all outputs 0 asynchronously, BTB empty afterwards.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_ctrl
// Brief    : Direct-mapped BTB with 2-bit counters, Fetch prediction, Execute
//            resolution/redirect and branch/mispredict statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 32 - IDX_W - 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      PCF,
    output logic             PredTakenF,
    output logic [31:0]      PredTargetF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic [31:0]      PCE,
    input  logic [31:0]      PCTargetE,
    input  logic [31:0]      PCPlus4E,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic             JalrE,
    input  logic             PCSrcE,
    output logic             MispredictE,
    output logic [31:0]      RedirectPCE,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MispredictCount
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic        PredD_q, PredD_d, PredE_q, PredE_d;
    logic [31:0] PredTargetD_q, PredTargetD_d, PredTargetE_q, PredTargetE_d;
    logic [CNT_W-1:0] BranchCount_q, MispredictCount_q;

    logic [IDX_W-1:0] w_idx_f, w_idx_e;
    logic [TAG_W-1:0] w_tag_f, w_tag_e;
    logic             w_hit_f, w_hit_e;
    logic             w_resolvable;
    logic             w_miss_a, w_miss_b, w_miss_c;
    logic [1:0]       w_ctr_upd;
    logic             w_unused;

    assign w_unused = ^{PCF[1:0], PCE[1:0]};

    // Fetch lookup reads the array before any same-cycle update lands.
    assign w_idx_f     = PCF[IDX_W+1:2];
    assign w_tag_f     = PCF[31:IDX_W+2];
    assign w_hit_f     = valid_q[w_idx_f] && (tag_q[w_idx_f] == w_tag_f);
    assign PredTakenF  = w_hit_f & ctr_q[w_idx_f][1];
    assign PredTargetF = PredTakenF ? target_q[w_idx_f] : (PCF + 32'd4);

    always_comb begin
        PredD_d       = PredD_q;
        PredTargetD_d = PredTargetD_q;
        PredE_d       = PredD_q;
        PredTargetE_d = PredTargetD_q;
        if (FlushD) begin
            PredD_d       = 1'b0;
            PredTargetD_d = 32'd0;
        end else if (!StallD) begin
            PredD_d       = PredTakenF;
            PredTargetD_d = PredTargetF;
        end
        if (FlushE) begin
            PredE_d       = 1'b0;
            PredTargetE_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PredD_q       <= 1'b0;
            PredTargetD_q <= 32'd0;
            PredE_q       <= 1'b0;
            PredTargetE_q <= 32'd0;
        end else begin
            PredD_q       <= PredD_d;
            PredTargetD_q <= PredTargetD_d;
            PredE_q       <= PredE_d;
            PredTargetE_q <= PredTargetE_d;
        end
    end

    assign w_idx_e      = PCE[IDX_W+1:2];
    assign w_tag_e      = PCE[31:IDX_W+2];
    assign w_hit_e      = valid_q[w_idx_e] && (tag_q[w_idx_e] == w_tag_e);
    assign w_resolvable = (BranchE | JumpE) & ~JalrE;
    assign w_miss_a     = w_resolvable & (PredE_q != PCSrcE);
    assign w_miss_b     = w_resolvable & PredE_q & PCSrcE & (PredTargetE_q != PCTargetE);
    // A taken prediction on a non-branch means an alias or stale entry.
    assign w_miss_c     = ~w_resolvable & PredE_q;
    assign MispredictE  = w_miss_a | w_miss_b | w_miss_c;
    assign RedirectPCE  = (w_resolvable & PCSrcE) ? PCTargetE : PCPlus4E;

    always_comb begin
        w_ctr_upd = ctr_q[w_idx_e];
        if (JumpE) begin
            w_ctr_upd = 2'b11;
        end else if (PCSrcE) begin
            if (ctr_q[w_idx_e] != 2'b11) w_ctr_upd = ctr_q[w_idx_e] + 2'd1;
        end else begin
            if (ctr_q[w_idx_e] != 2'b00) w_ctr_upd = ctr_q[w_idx_e] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (w_resolvable) begin
            if (w_hit_e) begin
                ctr_q[w_idx_e] <= w_ctr_upd;
                if (PCSrcE) target_q[w_idx_e] <= PCTargetE;
            end else if (PCSrcE) begin
                valid_q[w_idx_e]  <= 1'b1;
                tag_q[w_idx_e]    <= w_tag_e;
                target_q[w_idx_e] <= PCTargetE;
                ctr_q[w_idx_e]    <= JumpE ? 2'b11 : 2'b10;
            end
        end else if (PredE_q) begin
            valid_q[w_idx_e] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            BranchCount_q     <= '0;
            MispredictCount_q <= '0;
        end else begin
            if (w_resolvable && !(&BranchCount_q))
                BranchCount_q <= BranchCount_q + CNT_W'(1);
            if (MispredictE && !(&MispredictCount_q))
                MispredictCount_q <= MispredictCount_q + CNT_W'(1);
        end
    end

    assign BranchCount     = BranchCount_q;
    assign MispredictCount = MispredictCount_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_ctrl
// Brief    : Vector table, directed corner sequences and a randomized run
//            against a behavioural BTB model for branch_predict_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, PredTargetF, PCE, PCTargetE, PCPlus4E, RedirectPCE;
    logic        PredTakenF, StallD, FlushD, FlushE;
    logic        BranchE, JumpE, JalrE, PCSrcE, MispredictE;
    logic [31:0] BranchCount, MispredictCount;

    always #5 clk = ~clk;

    branch_predict_ctrl dut (
        .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF),
        .PredTargetF(PredTargetF), .StallD(StallD), .FlushD(FlushD),
        .FlushE(FlushE), .PCE(PCE), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
        .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .PCSrcE(PCSrcE),
        .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
        .BranchCount(BranchCount), .MispredictCount(MispredictCount)
    );

    typedef struct {
        logic [31:0] pcf;
        logic        stall, flushd, flushe;
        logic [31:0] pce, tgt;
        logic        br, j, jalr, src;
    } in_t;

    typedef struct {
        in_t         i;
        logic        pf;
        logic [31:0] tf;
        logic        mis;
        logic [31:0] red;
        int          bc, mc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic in_t mk(input logic [31:0] pcf, input logic [31:0] pce,
                               input logic [31:0] tgt, input logic br, input logic j,
                               input logic jalr, input logic src);
        in_t v;
        v.pcf = pcf; v.stall = 1'b0; v.flushd = 1'b0; v.flushe = 1'b0;
        v.pce = pce; v.tgt = tgt; v.br = br; v.j = j; v.jalr = jalr; v.src = src;
        return v;
    endfunction

    function automatic vec_t row(input in_t i, input logic pf, input logic [31:0] tf,
                                 input logic mis, input logic [31:0] red,
                                 input int bc, input int mc);
        vec_t r;
        r.i = i; r.pf = pf; r.tf = tf; r.mis = mis; r.red = red; r.bc = bc; r.mc = mc;
        return r;
    endfunction

    task automatic apply(input in_t v);
        PCF = v.pcf; StallD = v.stall; FlushD = v.flushd; FlushE = v.flushe;
        PCE = v.pce; PCTargetE = v.tgt; PCPlus4E = v.pce + 32'd4;
        BranchE = v.br; JumpE = v.j; JalrE = v.jalr; PCSrcE = v.src;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Behavioural model: 64 entries, index = (pc/4)%64, tag = pc/256.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    bit          m_pd, m_pe;
    logic [31:0] m_ptd, m_pte;
    int          m_bc, m_mc;

    task automatic m_reset();
        for (int k = 0; k < 64; k++) begin
            m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 1;
        end
        m_pd = 0; m_pe = 0; m_ptd = 0; m_pte = 0; m_bc = 0; m_mc = 0;
    endtask

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[(pc / 4) % 64] && (m_tag[(pc / 4) % 64] == pc / 256);
    endfunction

    task automatic m_step(input in_t v, input bit pt, input logic [31:0] ptgt,
                          input bit res, input bit mis);
        int k;
        k = (v.pce / 4) % 64;
        if (res) begin
            if (m_hit(v.pce)) begin
                if (v.j)        m_ctr[k] = 3;
                else if (v.src) m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
                else            m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
                if (v.src) m_tgt[k] = v.tgt;
            end else if (v.src) begin
                m_valid[k] = 1; m_tag[k] = v.pce / 256; m_tgt[k] = v.tgt;
                m_ctr[k] = v.j ? 3 : 2;
            end
        end else if (m_pe) begin
            m_valid[k] = 0;
        end
        if (v.flushe) begin m_pe = 0; m_pte = 0; end
        else          begin m_pe = m_pd; m_pte = m_ptd; end
        if (v.flushd)      begin m_pd = 0; m_ptd = 0; end
        else if (!v.stall) begin m_pd = pt; m_ptd = ptgt; end
        if (res) m_bc++;
        if (mis) m_mc++;
    endtask

    function automatic in_t rnd_in();
        logic [31:0] pool [5];
        logic [31:0] tg   [3];
        in_t v;
        int  kind;
        pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h140;
        pool[3] = 32'h300; pool[4] = 32'h1100;
        tg[0] = 32'h80; tg[1] = 32'h90; tg[2] = 32'h400;
        kind = $urandom_range(0, 5);
        v = mk(pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)],
               tg[$urandom_range(0, 2)], 1'b0, 1'b0, 1'b0, 1'b0);
        v.stall  = ($urandom_range(0, 7) == 0);
        v.flushd = ($urandom_range(0, 9) == 0);
        v.flushe = ($urandom_range(0, 9) == 0);
        case (kind)
            2, 3:    begin v.br = 1'b1; v.src = 1'($urandom_range(0, 1)); end
            4:       begin v.j = 1'b1; v.src = 1'b1; end
            5:       begin v.jalr = 1'b1; v.src = 1'b1; end
            default: v.src = 1'($urandom_range(0, 1));
        endcase
        return v;
    endfunction

    vec_t        tbl [21];
    in_t         v, idle, idl_e;
    bit          ept, eres, emis;
    logic [31:0] etf, ered;

    initial begin
        idle  = mk(32'h400, 32'h400, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idl_e = mk(32'h400, 32'h404, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[0]  = row(mk(32'h100, 32'h400, 0, 0, 0, 0, 0),        0, 32'h104, 0, 32'h404, 0, 0);
        tbl[1]  = row(mk(32'h100, 32'h100, 32'h80, 1, 0, 0, 1),   0, 32'h104, 1, 32'h80,  1, 1);
        tbl[2]  = row(mk(32'h100, 32'h400, 0, 0, 0, 0, 0),        1, 32'h80,  0, 32'h404, 1, 1);
        tbl[3]  = row(mk(32'h400, 32'h400, 0, 0, 0, 0, 0),        0, 32'h404, 0, 32'h404, 1, 1);
        tbl[4]  = row(mk(32'h400, 32'h100, 32'h80, 1, 0, 0, 0),   0, 32'h404, 1, 32'h104, 2, 2);
        tbl[5]  = row(mk(32'h400, 32'h100, 32'h80, 1, 0, 0, 0),   0, 32'h404, 0, 32'h104, 3, 2);
        tbl[6]  = row(mk(32'h100, 32'h400, 0, 0, 0, 0, 0),        0, 32'h104, 0, 32'h404, 3, 2);
        tbl[7]  = row(mk(32'h400, 32'h100, 32'h80, 1, 0, 0, 1),   0, 32'h404, 1, 32'h80,  4, 3);
        tbl[8]  = row(mk(32'h400, 32'h100, 32'h80, 1, 0, 0, 1),   0, 32'h404, 1, 32'h80,  5, 4);
        tbl[9]  = row(mk(32'h100, 32'h400, 0, 0, 0, 0, 0),        1, 32'h80,  0, 32'h404, 5, 4);
        tbl[10] = row(mk(32'h400, 32'h400, 0, 0, 0, 0, 0),        0, 32'h404, 0, 32'h404, 5, 4);
        tbl[11] = row(mk(32'h400, 32'h100, 32'h90, 1, 0, 0, 1),   0, 32'h404, 1, 32'h90,  6, 5);
        tbl[12] = row(mk(32'h100, 32'h400, 0, 0, 0, 0, 0),        1, 32'h90,  0, 32'h404, 6, 5);
        tbl[13] = row(mk(32'h400, 32'h400, 0, 0, 0, 0, 0),        0, 32'h404, 0, 32'h404, 6, 5);
        tbl[14] = row(mk(32'h400, 32'h100, 0, 0, 0, 0, 0),        0, 32'h404, 1, 32'h104, 6, 6);
        tbl[15] = row(mk(32'h100, 32'h400, 0, 0, 0, 0, 0),        0, 32'h104, 0, 32'h404, 6, 6);
        tbl[16] = row(mk(32'h400, 32'h200, 32'h300, 0, 1, 0, 1),  0, 32'h404, 1, 32'h300, 7, 7);
        tbl[17] = row(mk(32'h200, 32'h400, 0, 0, 0, 0, 0),        1, 32'h300, 0, 32'h404, 7, 7);
        tbl[18] = row(mk(32'h400, 32'h100, 32'h500, 0, 0, 1, 1),  0, 32'h404, 0, 32'h104, 7, 7);
        tbl[19] = row(mk(32'h100, 32'h400, 0, 0, 0, 0, 0),        0, 32'h104, 1, 32'h404, 7, 8);
        tbl[20] = row(mk(32'h200, 32'h400, 0, 0, 0, 0, 0),        0, 32'h204, 0, 32'h404, 7, 8);

        rst = 1'b0;
        apply(idle);
        #1;
        chk("rst_predF", {31'd0, PredTakenF}, 32'd0);
        chk("rst_misp", {31'd0, MispredictE}, 32'd0);
        chk("rst_bcnt", BranchCount, 32'd0);
        chk("rst_mcnt", MispredictCount, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 21; k++) begin
            apply(tbl[k].i);
            #1;
            chk($sformatf("row%0d_predF", k), {31'd0, PredTakenF}, {31'd0, tbl[k].pf});
            chk($sformatf("row%0d_tgtF", k), PredTargetF, tbl[k].tf);
            chk($sformatf("row%0d_misp", k), {31'd0, MispredictE}, {31'd0, tbl[k].mis});
            chk($sformatf("row%0d_redir", k), RedirectPCE, tbl[k].red);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_bcnt", k), BranchCount, tbl[k].bc);
            chk($sformatf("row%0d_mcnt", k), MispredictCount, tbl[k].mc);
            @(negedge clk);
        end

        // Flush beats stall on F->D, stall holds F->D, FlushE clears D->E.
        do_reset();
        apply(mk(32'h400, 32'h100, 32'h80, 1, 0, 0, 1)); @(negedge clk);
        v = mk(32'h100, 32'h404, 0, 0, 0, 0, 0); v.stall = 1'b1; v.flushd = 1'b1;
        apply(v); #1;
        chk("seq_trained_predF", {31'd0, PredTakenF}, 32'd1);
        @(negedge clk);
        apply(idl_e); @(negedge clk);
        apply(idl_e); #1;
        chk("seq_flush_over_stall", {31'd0, MispredictE}, 32'd0);
        @(negedge clk);
        apply(mk(32'h100, 32'h404, 0, 0, 0, 0, 0)); @(negedge clk);
        v = idl_e; v.stall = 1'b1;
        apply(v); @(negedge clk);
        apply(idl_e); #1;
        chk("seq_stall_first", {31'd0, MispredictE}, 32'd1);
        @(negedge clk);
        apply(idl_e); #1;
        chk("seq_stall_hold", {31'd0, MispredictE}, 32'd1);
        @(negedge clk);
        apply(mk(32'h100, 32'h404, 0, 0, 0, 0, 0)); @(negedge clk);
        v = idl_e; v.flushe = 1'b1;
        apply(v); @(negedge clk);
        apply(idl_e); #1;
        chk("seq_flushE", {31'd0, MispredictE}, 32'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of a cycle with state in flight.
        apply(mk(32'h100, 32'h404, 0, 0, 0, 0, 0)); @(negedge clk);
        apply(idl_e); @(negedge clk);
        apply(idl_e); #1;
        chk("seq_pre_rst_misp", {31'd0, MispredictE}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("seq_arst_misp", {31'd0, MispredictE}, 32'd0);
        chk("seq_arst_bcnt", BranchCount, 32'd0);
        chk("seq_arst_mcnt", MispredictCount, 32'd0);
        apply(mk(32'h100, 32'h404, 0, 0, 0, 0, 0)); #1;
        chk("seq_arst_predF", {31'd0, PredTakenF}, 32'd0);
        chk("seq_arst_tgtF", PredTargetF, 32'h104);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk("seq_btb_empty", {31'd0, PredTakenF}, 32'd0);
        @(negedge clk);

        do_reset();
        m_reset();
        for (int n = 0; n < 500; n++) begin
            v = rnd_in();
            apply(v);
            #1;
            ept  = m_hit(v.pcf) && (m_ctr[(v.pcf / 4) % 64] >= 2);
            etf  = ept ? m_tgt[(v.pcf / 4) % 64] : v.pcf + 32'd4;
            eres = (v.br || v.j) && !v.jalr;
            emis = eres ? ((m_pe != v.src) || (m_pe && v.src && (m_pte != v.tgt))) : m_pe;
            ered = (eres && v.src) ? v.tgt : v.pce + 32'd4;
            chk("rnd_predF", {31'd0, PredTakenF}, {31'd0, ept});
            chk("rnd_tgtF", PredTargetF, etf);
            chk("rnd_misp", {31'd0, MispredictE}, {31'd0, emis});
            chk("rnd_redir", RedirectPCE, ered);
            @(posedge clk);
            m_step(v, ept, etf, eres, emis);
            #1;
            chk("rnd_bcnt", BranchCount, m_bc);
            chk("rnd_mcnt", MispredictCount, m_mc);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
